// File: rtl/acc_pkg.sv
// Shared definitions for the running-sum accumulator: state encoding and
// default datapath widths used by the sequencer, its adder and its bus.
package acc_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_COUNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2,
      HALT = 2'd3
   } acc_state_t;

endpackage

// File: rtl/accum_sequencer_if.sv
// Operand handshake between an upstream source and the accumulator.
// The master drives op_valid/op_data; the slave answers with op_ready.
interface accum_sequencer_if #(
   parameter int WIDTH = acc_pkg::DEF_WIDTH
);

   logic             op_valid;
   logic [WIDTH-1:0] op_data;
   logic             op_ready;

   modport master (
      output op_valid,
      output op_data,
      input  op_ready
   );

   modport slave (
      input  op_valid,
      input  op_data,
      output op_ready
   );

endinterface

// File: rtl/acc_adder.sv
// Pure WIDTH-bit adder with carry-out and no carry-in; the sequencer
// decides what to do with the carry.
module acc_adder #(
   parameter int WIDTH = acc_pkg::DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             c
);

   // Widen by one bit so the top bit of the result is the carry-out.
   assign {c, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/accum_sequencer.sv
// Accumulator controller and datapath. Operands arrive over a valid/ready
// handshake, are captured, added into the running sum one cycle later and
// reported with a one-cycle done pulse. A carry-out sets a sticky overflow
// flag and, when STOP_ON_OVF is set, parks the block in HALT until software
// acknowledges or clears.
module accum_sequencer
   import acc_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int COUNT_W     = DEF_COUNT_W,
   parameter bit STOP_ON_OVF = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   accum_sequencer_if.slave    op_bus,
   input  logic                clear_acc,
   input  logic                ovf_ack,
   output logic [WIDTH-1:0]    a_reg,
   output logic [WIDTH-1:0]    sum,
   output logic                ovf,
   output logic [COUNT_W-1:0]  op_count,
   output logic                busy,
   output logic                done,
   output logic                halted
);

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

   acc_state_t       state;
   logic [WIDTH-1:0] add_s;
   logic             add_c;

   acc_adder #(.WIDTH(WIDTH)) u_adder (
      .a (sum),
      .b (a_reg),
      .s (add_s),
      .c (add_c)
   );

   // A pending clear blocks acceptance so clear always wins over an operand.
   assign op_bus.op_ready = (state == IDLE) && !clear_acc;

   // Sequencer: capture -> add -> complete, with overflow halt and clear paths.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_reg    <= '0;
         sum      <= '0;
         ovf      <= 1'b0;
         op_count <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         halted   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_acc) begin
                  sum      <= '0;
                  ovf      <= 1'b0;
                  op_count <= '0;
               end else if (op_bus.op_valid) begin
                  a_reg <= op_bus.op_data;
                  if (op_count != COUNT_MAX) begin
                     op_count <= op_count + 1'b1;
                  end
                  state <= ADD;
                  busy  <= 1'b1;
               end
            end
            ADD: begin
               sum <= add_s;
               if (add_c) begin
                  ovf <= 1'b1;
               end
               if (add_c && STOP_ON_OVF) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            HALT: begin
               if (clear_acc) begin
                  sum      <= '0;
                  ovf      <= 1'b0;
                  op_count <= '0;
                  state    <= IDLE;
                  busy     <= 1'b0;
                  halted   <= 1'b0;
               end else if (ovf_ack) begin
                  ovf    <= 1'b0;
                  state  <= IDLE;
                  busy   <= 1'b0;
                  halted <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
Controller plus datapath for the running-sum accumulator: operand register, WIDTH-bit adder, sum register and carry flag.
- Operands are taken from an upstream valid/ready source instead of raw switch/key strobes.
- The FSM sequences capture → add → complete, keeps a sticky overflow flag and counts accepted operations.
- On overflow it can optionally halt until software acknowledges.
- Outputs drive LEDs/7-seg decoders directly.

Parameters:
- WIDTH, 8, operand and sum width.
- COUNT_W, 8, width of the accepted-operation counter.
- STOP_ON_OVF, 1, 1 = enter HALT on carry-out; 0 = flag and continue.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  operand available.
- op_data  in  WIDTH  operand value.
- op_ready  out  1  block can accept an operand this cycle.
- clear_acc  in  1  clear sum/ovf/count request.
- ovf_ack  in  1  leave HALT.
- a_reg  out  WIDTH  last captured operand.
- sum  out  WIDTH  accumulated value (wraps mod 2^WIDTH).
- ovf  out  1  sticky carry-out flag.
- op_count  out  COUNT_W  accepted operations, saturating.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse per completed add.
- halted  out  1  state == HALT.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset, sampled at posedge clk:
  - state = IDLE.
  - a_reg, sum, op_count = 0.
  - ovf, done = 0.
  - rst overrides all other inputs in every state, including mid-sequence.
- States: IDLE, ADD, DONE, HALT.
- op_ready = (state == IDLE) & ~clear_acc. Combinational; the only combinational output.
- IDLE:
  - If clear_acc: sum=0, ovf=0, op_count=0, a_reg unchanged, stay IDLE. Clear wins over op_valid; no accept that cycle.
  - Else if op_valid: accept at edge T. a_reg <= op_data, op_count++ (holds at 2^COUNT_W-1), → ADD.
- ADD (cycle after T):
  - Compute {c, s} = sum + a_reg, WIDTH+1 bits, no carry-in.
  - At edge T+1: sum <= s. If c, ovf <= 1. ovf never clears here.
  - If c & STOP_ON_OVF → HALT; else → DONE.
- DONE: done=1 for exactly this cycle, → IDLE at edge T+2.
  - Latency: accept to done = 2 cycles; max throughput 1 operand per 3 cycles.
- HALT:
  - op_ready=0; sum holds the wrapped value; done is not pulsed.
  - ovf_ack: ovf <= 0, → IDLE.
  - clear_acc: full clear, → IDLE. If both, clear wins (clear implies ack).
- clear_acc and ovf_ack are ignored in ADD and DONE; the requester must hold them until op_ready or halted is observed.
- With STOP_ON_OVF=0, ovf stays set until clear_acc.
- op_data is only sampled on the accept edge; changes at other times have no effect.
- All outputs other than op_ready are registered.

Decomposition:
- Shared package acc_pkg:
  - State encoding: IDLE=2'd0, ADD=2'd1, DONE=2'd2, HALT=2'd3.
  - Default WIDTH/COUNT_W constants.
- One natural sub-module: acc_adder. Pure WIDTH-bit add with carry-out. The FSM, registers and counter stay in accum_sequencer.

Test Plan:
1. Reset, then op_valid with 8'h05, 8'h0A, 8'h20 back-to-back (valid held high):
   - Accepts exactly 3 cycles apart; done pulses 2 cycles after each accept.
   - Final sum=8'h2F, op_count=3, ovf=0.
2. Overflow with STOP_ON_OVF=1: sum=8'hF0, then add 8'h20:
   - sum=8'h10, ovf=1, halted=1, no done pulse, op_ready=0 while op_valid is held.
   - Then ovf_ack: IDLE, ovf=0, sum stays 8'h10.
3. Overflow with STOP_ON_OVF=0: sum=8'hFF, add 8'h01:
   - sum=8'h00, ovf=1, done pulses, next operand accepted normally, ovf stays 1 until clear_acc.
4. clear_acc asserted together with op_valid in IDLE (sum=8'h33):
   - op_ready=0; next cycle sum=0, op_count=0.
   - clear_acc asserted during ADD: ignored, sum updates normally.
5. rst asserted during ADD after accepting 8'h7F with sum=8'h01:
   - Next cycle all outputs 0 and state IDLE; the pending add is discarded.
6. COUNT_W=2, 5 accepted operands:
   - op_count saturates at 3; sum still accumulates all 5 operands.
